// File: rtl/toggle_counter_pkg.sv
// Shared constants and helpers for the toggle-cell modulo counter.
package toggle_counter_pkg;

  localparam int unsigned TC_WIDTH_DEFAULT   = 4;
  localparam int unsigned TC_MODULUS_DEFAULT = 16;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Highest legal count: the up-wrap source and the down-wrap target.
  function automatic int unsigned wrap_target(input int unsigned modulus);
    return modulus - 1;
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/toggle_counter_tff_cell.sv
// Single-bit toggle flip-flop with synchronous active-high reset.
module tff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/toggle_counter.sv
// Up/down modulo counter: a toggle-mask generator driving a row of tff_cell instances.
module toggle_counter
  import toggle_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = TC_WIDTH_DEFAULT,
  parameter int unsigned MODULUS = TC_MODULUS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(wrap_target(MODULUS));
  localparam bit               POW2_MOD = is_pow2(MODULUS);

  logic [WIDTH-1:0] inc_q;
  logic [WIDTH-1:0] dec_q;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             at_max;
  logic             at_zero;

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == '0);

  // A power-of-two modulus wraps through the natural carry/borrow chain.
  generate
    if (POW2_MOD) begin : g_pow2
      assign inc_q = q + 1'b1;
      assign dec_q = q - 1'b1;
    end else begin : g_mod
      assign inc_q = at_max  ? '0    : q + 1'b1;
      assign dec_q = at_zero ? MAX_Q : q - 1'b1;
    end
  endgenerate

  assign load_q = (d > MAX_Q) ? MAX_Q : d;

  // Ternaries, not if/else, so X on en/up propagates into the toggle mask.
  always_comb begin
    count_q = (up == DIR_UP) ? inc_q : dec_q;
    nxt     = load ? load_q : (en ? count_q : q);
    t       = q ^ nxt;
  end

  assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      tff_cell u_cell (
        .clk (clk),
        .rst (rst),
        .t   (t[i]),
        .q   (q[i]),
        .qb  (qb[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_toggle_counter.sv
// Directed bench for toggle_counter with WIDTH=4, MODULUS=10.
module tb_toggle_counter;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned MODULUS = 10;

  logic             clk;
  logic             rst;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic             tc;

  int checks_total;
  int checks_passed;

  toggle_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .qb   (qb),
    .tc   (tc)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] value);
    load = 1'b1;
    d    = value;
    step();
    load = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst  = 1'b1;
    en   = 1'b1;
    up   = 1'b1;
    load = 1'b0;
    d    = '0;

    // Reset held two cycles with en=1
    step();
    step();
    check("rst_q", 32'(q), 32'd0);
    check("rst_qb", 32'(qb), 32'hF);
    check("rst_tc", 32'(tc), 32'd0);
    rst = 1'b0;
    step(); check("post_rst_q1", 32'(q), 32'd1);
    step(); check("post_rst_q2", 32'(q), 32'd2);
    step(); check("post_rst_q3", 32'(q), 32'd3);
    check("post_rst_qb3", 32'(qb), 32'hC);

    // Up count through the wrap
    do_load(4'd0);
    en = 1'b1;
    up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("up_q", 32'(q), 32'(i));
      check("up_tc", 32'(tc), (i == 9) ? 32'd1 : 32'd0);
      step();
    end
    check("up_wrap_q", 32'(q), 32'd0);

    // Down count through the wrap
    do_load(4'd1);
    up = 1'b0;
    check("dn_q1", 32'(q), 32'd1);
    check("dn_tc1", 32'(tc), 32'd0);
    step();
    check("dn_q0", 32'(q), 32'd0);
    check("dn_tc0", 32'(tc), 32'd1);
    step();
    check("dn_q9", 32'(q), 32'd9);
    check("dn_tc9", 32'(tc), 32'd0);
    step();
    check("dn_q8", 32'(q), 32'd8);

    // Load priority and clamping
    en = 1'b1; up = 1'b1;
    do_load(4'd6);
    check("load6_q", 32'(q), 32'd6);
    do_load(4'd12);
    check("load12_clamp", 32'(q), 32'd9);
    do_load(4'd15);
    check("load15_clamp", 32'(q), 32'd9);
    do_load(4'd9);
    check("load9_edge", 32'(q), 32'd9);
    load = 1'b1;
    d    = 4'd3;
    #1;
    check("tc_load_gate", 32'(tc), 32'd0);
    rst = 1'b1;
    step();
    check("rst_over_load", 32'(q), 32'd0);
    rst  = 1'b0;
    load = 1'b0;

    // Hold, then direction change each cycle
    do_load(4'd7);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_q", 32'(q), 32'd7);
      check("hold_tc", 32'(tc), 32'd0);
    end
    en = 1'b1;
    up = 1'b1; step(); check("dir_q8a", 32'(q), 32'd8);
    up = 1'b0; step(); check("dir_q7a", 32'(q), 32'd7);
    up = 1'b1; step(); check("dir_q8b", 32'(q), 32'd8);
    up = 1'b0; step(); check("dir_q7b", 32'(q), 32'd7);

    // Reset mid-count
    do_load(4'd5);
    up  = 1'b1;
    rst = 1'b1;
    step();
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_qb", 32'(qb), 32'hF);
    rst = 1'b0;
    step();
    check("mid_rst_resume_up", 32'(q), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    up  = 1'b0;
    step();
    check("mid_rst_resume_dn", 32'(q), 32'd9);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
